// File: rtl/serial_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : serial_pkg                                                 |
// | Purpose : Shared frame geometry and state encoding for the serial    |
// |           receiver and transmitter.                                  |
// | Contents: DATA_BITS, FRAME_BITS, IDLE_LEVEL, CNT_W, state_t          |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package serial_pkg;

  // Payload width, full frame length (start + data + parity + stop) and
  // the level the line rests at between frames.
  localparam int   DATA_BITS  = 7;
  localparam int   FRAME_BITS = 10;
  localparam logic IDLE_LEVEL = 1'b1;

  // Bit counter width, wide enough to index every payload bit.
  localparam int   CNT_W      = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DATA      = 3'd1,
    PARITY    = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

endpackage : serial_pkg
`default_nettype wire

// File: rtl/receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : receiver                                                   |
// | Purpose : Serial frame receiver, one bit per clock. Frame is start   |
// |           (0), D0..D6 LSB first, even-parity bit, stop (1). Good     |
// |           frames are handed to a valid/ready consumer; bad parity    |
// |           is flagged but still delivered.                            |
// | Ports   : clk        - clock, serial_in sampled on every rising edge |
// |           rst        - synchronous active-high reset                 |
// |           serial_in  - serial line, idles high                       |
// |           ready      - consumer accepts when ready && valid          |
// |           data_out   - payload of the last accepted frame            |
// |           valid      - data_out/parity_err hold an unconsumed frame  |
// |           parity_err - frame in data_out failed the parity check     |
// |           frame_err  - one-cycle pulse on a low stop bit             |
// |           overrun    - sticky, a frame was dropped while pending     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module receiver
  import serial_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(DATA_BITS - 1);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;

  logic                 w_complete;
  logic                 w_accept;
  logic                 w_par_bad;

  // A frame completes on the edge that samples a high stop bit.
  assign w_complete = (r_state == STOP) && (serial_in == IDLE_LEVEL);

  // The holding register can take the new frame if it is empty or is
  // being drained in this very cycle.
  assign w_accept   = !valid || ready;

  // Parity bit plus data must hold an even number of ones.
  assign w_par_bad  = r_par ^ (^r_shift);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      // Output handshake: a completion takes priority over a plain drain
      // because loading a new frame also retires the old one.
      if (w_complete) begin
        if (w_accept) begin
          data_out   <= r_shift;
          parity_err <= w_par_bad;
          valid      <= 1'b1;
        end else begin
          overrun    <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (serial_in != IDLE_LEVEL) begin
            r_state <= DATA;
            r_cnt   <= '0;
          end
        end

        DATA: begin
          r_shift[r_cnt] <= serial_in;
          if (r_cnt == C_LAST_BIT) begin
            r_cnt   <= '0;
            r_state <= PARITY;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end

        PARITY: begin
          r_par   <= serial_in;
          r_state <= STOP;
        end

        STOP: begin
          if (serial_in == IDLE_LEVEL) begin
            // Straight back to IDLE so a start bit on the next cycle is
            // picked up without a gap.
            r_state <= IDLE;
          end else begin
            frame_err <= 1'b1;
            r_state   <= WAIT_HIGH;
          end
        end

        WAIT_HIGH: begin
          // A low line after a framing error is not a start bit.
          if (serial_in == IDLE_LEVEL) begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : receiver
`default_nettype wire

// File: tb/tb_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_receiver                                                |
// | Purpose : Self-checking bench for receiver. The bench builds the     |
// |           serial line itself, so it knows at which cycle every frame |
// |           completes or fails; a small handshake model turns those    |
// |           events into expected outputs.                              |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_receiver;

  localparam int C_EV_NONE = 0;
  localparam int C_EV_DONE = 1;
  localparam int C_EV_FERR = 2;
  localparam int C_RD_LOW  = 0;
  localparam int C_RD_HIGH = 1;
  localparam int C_RD_RAND = 2;

  logic       clk;
  logic       rst;
  logic       serial_in;
  logic       ready;
  logic [6:0] data_out;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  int n_tests;
  int n_fail;

  // Reference model of the consumer-facing outputs.
  logic [6:0] m_data;
  logic       m_valid;
  logic       m_perr;
  logic       m_ferr;
  logic       m_ovr;

  receiver u_dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .ready      (ready),
    .data_out   (data_out),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_all();
    check("data_out",   {1'b0, data_out}, {1'b0, m_data});
    check("valid",      {7'd0, valid},      {7'd0, m_valid});
    check("parity_err", {7'd0, parity_err}, {7'd0, m_perr});
    check("frame_err",  {7'd0, frame_err},  {7'd0, m_ferr});
    check("overrun",    {7'd0, overrun},    {7'd0, m_ovr});
  endtask

  function automatic logic pick(input int mode);
    if (mode == C_RD_RAND) return logic'($urandom_range(0, 1));
    return (mode == C_RD_HIGH);
  endfunction

  // Drive one line bit; evt says what the bench expects this sample to mean.
  task automatic drive_bit(input logic b, input logic rd, input int evt,
                           input logic [6:0] d, input logic p);
    serial_in = b;
    ready     = rd;
    @(posedge clk);
    if (evt == C_EV_DONE) begin
      if (!m_valid || rd) begin
        m_data  = d;
        m_perr  = ($countones({d, p}) % 2) != 0;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && rd) begin
      m_valid = 1'b0;
    end
    m_ferr = (evt == C_EV_FERR);
    #1;
    check_all();
  endtask

  task automatic idle_bits(input int n, input int rmode);
    for (int i = 0; i < n; i++) drive_bit(1'b1, pick(rmode), C_EV_NONE, 7'd0, 1'b0);
  endtask

  task automatic send_frame(input logic [6:0] d, input logic p, input logic stp,
                            input int rbody, input int rstop);
    drive_bit(1'b0, pick(rbody), C_EV_NONE, 7'd0, 1'b0);
    for (int i = 0; i < 7; i++) drive_bit(d[i], pick(rbody), C_EV_NONE, 7'd0, 1'b0);
    drive_bit(p, pick(rbody), C_EV_NONE, 7'd0, 1'b0);
    drive_bit(stp, pick(rstop), stp ? C_EV_DONE : C_EV_FERR, d, p);
  endtask

  task automatic do_reset(input logic line);
    rst       = 1'b1;
    serial_in = line;
    ready     = 1'b0;
    @(posedge clk);
    m_data = '0; m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    #1;
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    logic [6:0] d;
    logic       p;
    logic       stp;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; serial_in = 1'b1; ready = 1'b0;
    m_data = '0; m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    repeat (2) @(posedge clk);
    do_reset(1'b1);
    idle_bits(2, C_RD_HIGH);

    // 7'h55 with correct parity, consumer always ready.
    send_frame(7'h55, 1'b0, 1'b1, C_RD_HIGH, C_RD_HIGH);
    idle_bits(2, C_RD_HIGH);

    // 7'h01 with P = 0: delivered with parity_err.
    send_frame(7'h01, 1'b0, 1'b1, C_RD_HIGH, C_RD_HIGH);
    idle_bits(2, C_RD_HIGH);

    // 7'h2A with a low stop bit, line held low three more cycles.
    send_frame(7'h2A, 1'b1, 1'b0, C_RD_HIGH, C_RD_HIGH);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b1, C_EV_NONE, 7'd0, 1'b0);
    idle_bits(3, C_RD_HIGH);

    // Back-to-back 7'h11 / 7'h22 with no consumer: second one overruns.
    do_reset(1'b1);
    send_frame(7'h11, 1'b0, 1'b1, C_RD_LOW, C_RD_LOW);
    send_frame(7'h22, 1'b0, 1'b1, C_RD_LOW, C_RD_LOW);
    idle_bits(2, C_RD_LOW);
    check("ovr_data", {1'b0, data_out}, 8'h11);

    // Same pair, ready pulsed on the second completion cycle.
    do_reset(1'b1);
    send_frame(7'h11, 1'b0, 1'b1, C_RD_LOW, C_RD_LOW);
    send_frame(7'h22, 1'b0, 1'b1, C_RD_LOW, C_RD_HIGH);
    idle_bits(2, C_RD_LOW);
    check("swap_data", {1'b0, data_out}, 8'h22);
    check("swap_ovr",  {7'd0, overrun},  8'h00);

    // Reset while D3 is on the line, then a clean 7'h3C.
    do_reset(1'b1);
    drive_bit(1'b0, 1'b1, C_EV_NONE, 7'd0, 1'b0);
    drive_bit(1'b0, 1'b1, C_EV_NONE, 7'd0, 1'b0);
    drive_bit(1'b0, 1'b1, C_EV_NONE, 7'd0, 1'b0);
    drive_bit(1'b1, 1'b1, C_EV_NONE, 7'd0, 1'b0);
    do_reset(1'b1);
    idle_bits(2, C_RD_HIGH);
    send_frame(7'h3C, 1'b0, 1'b1, C_RD_LOW, C_RD_LOW);
    idle_bits(1, C_RD_LOW);
    check("rst_data", {1'b0, data_out},   8'h3C);
    check("rst_perr", {7'd0, parity_err}, 8'h00);
    idle_bits(2, C_RD_HIGH);

    // Randomized traffic: random payloads, parity, stop errors, gaps, ready.
    for (int f = 0; f < 60; f++) begin
      d   = 7'($urandom_range(0, 127));
      p   = logic'($urandom_range(0, 1));
      stp = ($urandom_range(0, 99) >= 15);
      send_frame(d, p, stp, C_RD_RAND, C_RD_RAND);
      if (!stp) begin
        for (int i = 0; i < int'($urandom_range(0, 3)); i++)
          drive_bit(1'b0, pick(C_RD_RAND), C_EV_NONE, 7'd0, 1'b0);
        idle_bits(int'($urandom_range(1, 2)), C_RD_RAND);
      end else begin
        idle_bits(int'($urandom_range(0, 3)), C_RD_RAND);
      end
    end
    idle_bits(4, C_RD_RAND);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_receiver
`default_nettype wire
